uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 168: CLOCK cycles per serial bit period.
REQ-002 SHALL provide parameter CNT_WIDTH, default 8: bit-period counter width; CLKS_PER_BIT SHALL satisfy 2 <= CLKS_PER_BIT <= 2^CNT_WIDTH.
REQ-003 SHALL provide port CLOCK  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL provide port RESET  input  1  reset, asynchronous and active-high.
REQ-005 SHALL provide port tx_data  input  8  byte to transmit; sampled only on acceptance.
REQ-006 SHALL provide port tx_valid  input  1  byte request.
REQ-007 SHALL provide port tx_ready  output  1  high when a byte can be accepted.
REQ-008 SHALL provide port tx_out  output  1  serial line; idle high.
REQ-009 SHALL provide port tx_busy  output  1  high while a frame is on the line.

Function
REQ-010 SHALL accept a byte on a rising edge where tx_valid=1 and tx_ready=1, and SHALL register tx_data into a shift register on that edge.
REQ-011 SHALL implement states IDLE, START, DATA, PARITY (only when configured), STOP: IDLE->START on acceptance; START->DATA, DATA->PARITY or STOP after bit 7, PARITY->STOP, STOP->IDLE, each after exactly CLKS_PER_BIT cycles in the state.
REQ-012 SHALL drive tx_out registered: 0 in START, current data bit in DATA, parity bit in PARITY, 1 in STOP and IDLE.
REQ-013 SHALL transmit data LSB first, bit 0 through bit 7, each held for exactly CLKS_PER_BIT cycles.
REQ-014 SHALL make tx_out go low on the first cycle after the acceptance edge (one-cycle latency).
REQ-015 SHALL hold tx_ready=1 only in IDLE and tx_busy=1 in all other states; tx_ready and tx_busy SHALL be registered and mutually exclusive.
REQ-016 SHALL return to IDLE with tx_ready=1 on the cycle after the last STOP cycle, so back-to-back frames have exactly one stop bit plus one idle cycle between them.
REQ-017 SHALL ignore tx_valid and tx_data changes while tx_ready=0; no request SHALL be queued.
REQ-018 SHALL use a down-counter loaded with CLKS_PER_BIT-1 on each state entry, advancing state at count 0; the counter SHALL never wrap.
REQ-019 SHALL produce total frame length of 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity) from first low cycle to end of stop bit.

Reset
REQ-020 SHALL on RESET=1 immediately (no clock needed) force state IDLE, tx_out=1, tx_ready=1, tx_busy=0, counter and shift register 0.
REQ-021 SHALL abort any frame in progress when RESET asserts mid-frame; no partial frame SHALL resume after release.
REQ-022 SHALL accept a new byte on the first rising edge after RESET deasserts if tx_valid=1.

Configuration
REQ-023 SHALL compile in an even-parity bit when macro UART_TX_PARITY_EN is defined: PARITY state after bit 7 driving XOR of the 8 accepted data bits.
REQ-024 SHALL omit PARITY state and parity logic entirely when UART_TX_PARITY_EN is undefined, going DATA->STOP directly.

Verification
REQ-025 SHALL verify basic frame: CLKS_PER_BIT=168, send 0x55 -> tx_out low 168 cycles, then 1,0,1,0,1,0,1,0 each 168 cycles, high 168 cycles, tx_ready=1 at cycle 1681 after acceptance.
REQ-026 SHALL verify back-to-back: tx_valid held high with 0xA5 then 0x3C -> two frames separated by one stop bit plus one idle cycle; bits LSB first (1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0).
REQ-027 SHALL verify busy ignore: change tx_data to 0xFF mid-frame of 0x00 with tx_valid=1 -> all eight data bits stay 0, no second frame unless tx_valid high when tx_ready returns.
REQ-028 SHALL verify reset mid-frame: assert RESET during bit 3 of 0x0F -> tx_out=1, tx_ready=1, tx_busy=0 same cycle; after release, sending 0x81 yields a clean full frame.
REQ-029 SHALL verify parity with UART_TX_PARITY_EN defined: 0x07 -> parity bit 1, 0x03 -> parity bit 0, frame length 1848 cycles at CLKS_PER_BIT=168; undefined -> 1680 cycles.
REQ-030 SHALL verify minimum bit period: CLKS_PER_BIT=2, send 0xC3 -> each bit exactly 2 cycles, frame 20 cycles.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a valid/ready byte interface and registered outputs.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between bit 7 and the stop bit.
module uart_tx #(
  parameter int CLKS_PER_BIT = 168,
  parameter int CNT_WIDTH    = 8
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       tx_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic [2:0]           bit_q, bit_d;
  logic                 tx_out_q, tx_out_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 cnt_zero;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign cnt_zero = (cnt_q == '0);

  // State register. NOTE: sequential state uses non-blocking assignments so every
  // flop samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      bit_q      <= '0;
      tx_out_q   <= 1'b1;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      tx_out_q   <= tx_out_d;
      tx_ready_q <= tx_ready_d;
      tx_busy_q  <= tx_busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  // Next-state logic. NOTE: every signal gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    bit_d   = bit_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (tx_valid && tx_ready_q) begin
          state_d = S_START;
          cnt_d   = CNT_LOAD;
          shift_d = tx_data;
          bit_d   = '0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end
      S_START: begin
        if (cnt_zero) begin
          state_d = S_DATA;
          cnt_d   = CNT_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DATA: begin
        if (cnt_zero) begin
          cnt_d = CNT_LOAD;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (cnt_zero) begin
          state_d = S_STOP;
          cnt_d   = CNT_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
`endif
      S_STOP: begin
        if (cnt_zero) begin
          state_d = S_IDLE;
          cnt_d   = CNT_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered line changes
  // on the same edge as the state itself.
  always_comb begin
    tx_out_d = 1'b1;
    unique case (state_d)
      S_START:  tx_out_d = 1'b0;
      S_DATA:   tx_out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_out_d = parity_d;
`endif
      default:  tx_out_d = 1'b1;
    endcase
    tx_ready_d = (state_d == S_IDLE);
    tx_busy_d  = ~tx_ready_d;
  end

  assign tx_out   = tx_out_q;
  assign tx_ready = tx_ready_q;
  assign tx_busy  = tx_busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx; a CLKS_PER_BIT=168 instance and a
// CLKS_PER_BIT=2 / CNT_WIDTH=1 instance are checked against an expected-frame model.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int CPB0 = 168;
  localparam int CPB1 = 2;

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic       valid0, valid1;
  logic [7:0] data0, data1;
  logic       ready0, ready1, out0, out1, busy0, busy1;

  int total = 0;
  int bad   = 0;

  uart_tx #(.CLKS_PER_BIT(CPB0), .CNT_WIDTH(8)) dut0 (
    .CLOCK(CLOCK), .RESET(RESET), .tx_data(data0), .tx_valid(valid0),
    .tx_ready(ready0), .tx_out(out0), .tx_busy(busy0)
  );

  uart_tx #(.CLKS_PER_BIT(CPB1), .CNT_WIDTH(1)) dut1 (
    .CLOCK(CLOCK), .RESET(RESET), .tx_data(data1), .tx_valid(valid1),
    .tx_ready(ready1), .tx_out(out1), .tx_busy(busy1)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    bit         sel;
    logic [7:0] data;
    logic       exp_par;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin valid1 = v; data1 = d; end
    else     begin valid0 = v; data0 = d; end
  endtask

  function automatic logic get_out(input bit sel);
    return sel ? out1 : out0;
  endfunction
  function automatic logic get_ready(input bit sel);
    return sel ? ready1 : ready0;
  endfunction
  function automatic logic get_busy(input bit sel);
    return sel ? busy1 : busy0;
  endfunction

  // Requests a byte, then checks every line cycle of the frame against the
  // expected bit sequence, plus ready/busy and the frame length.
  // Called just after a falling edge; returns just after the falling edge of
  // the first idle cycle. 'waited' counts cycles spent before acceptance.
  task automatic frame(input bit sel, input logic [7:0] data, input logic exp_par,
                       input string tag, input bit keep_valid,
                       input logic [7:0] next_data, input int drop_at,
                       output int waited);
    int   cpb;
    logic exp_bits[NB];
    int   bit_err[NB + 1];
    int   hs_err;
    int   first_ready;
    cpb = sel ? CPB1 : CPB0;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[1 + i] = data[i];
    if (NB == 11) exp_bits[9] = exp_par;
    exp_bits[NB - 1] = 1'b1;
    for (int i = 0; i <= NB; i++) bit_err[i] = 0;
    hs_err      = 0;
    first_ready = -1;
    waited      = 0;

    set_in(sel, 1'b1, data);
    while (!get_ready(sel) && waited < 4000) begin
      @(negedge CLOCK);
      waited++;
    end
    if (waited >= 4000) begin
      check({tag, "_accept_timeout"}, waited, 0);
      set_in(sel, 1'b0, data);
      return;
    end
    @(posedge CLOCK);
    #1;
    set_in(sel, keep_valid, keep_valid ? next_data : data);

    for (int c = 1; c <= NB * cpb + 1; c++) begin
      int   idx;
      logic exp_line;
      logic exp_rdy;
      @(negedge CLOCK);
      if (c == drop_at) set_in(sel, 1'b0, next_data);
      idx      = (c - 1) / cpb;
      exp_line = (c <= NB * cpb) ? exp_bits[idx] : 1'b1;
      exp_rdy  = (c == NB * cpb + 1);
      if (get_out(sel) !== exp_line) bit_err[idx]++;
      if (get_ready(sel) !== exp_rdy || get_busy(sel) !== ~exp_rdy) hs_err++;
      if (get_ready(sel) === 1'b1 && first_ready < 0) first_ready = c;
    end
    for (int i = 0; i <= NB; i++)
      check($sformatf("%s_bit%0d_err_cycles", tag, i), bit_err[i], 0);
    check({tag, "_ready_busy_err_cycles"}, hs_err, 0);
    check({tag, "_ready_return_cycle"}, first_ready, NB * cpb + 1);
  endtask

  vec_t vecs[$];

  initial begin
    int waited;
    int errs;
    logic [7:0] d;

    vecs.push_back('{sel: 1'b0, data: 8'h07, exp_par: 1'b1});
    vecs.push_back('{sel: 1'b0, data: 8'h03, exp_par: 1'b0});
    vecs.push_back('{sel: 1'b1, data: 8'hC3, exp_par: 1'b0});
    vecs.push_back('{sel: 1'b1, data: 8'h01, exp_par: 1'b1});
    vecs.push_back('{sel: 1'b1, data: 8'h80, exp_par: 1'b1});
    vecs.push_back('{sel: 1'b1, data: 8'hFE, exp_par: 1'b1});
    vecs.push_back('{sel: 1'b1, data: 8'hFF, exp_par: 1'b0});
    vecs.push_back('{sel: 1'b1, data: 8'h00, exp_par: 1'b0});

    // Reset applies with no clock edge yet; request already pending at release.
    RESET = 1'b1;
    set_in(1'b0, 1'b1, 8'h55);
    set_in(1'b1, 1'b0, 8'h00);
    #2;
    check("reset_async_out",   out0,   1);
    check("reset_async_ready", ready0, 1);
    check("reset_async_busy",  busy0,  0);
    repeat (3) @(posedge CLOCK);
    check("reset_held_ready", ready1, 1);
    @(negedge CLOCK);
    RESET = 1'b0;

    // Basic 0x55 frame, accepted on the first edge after reset release.
    frame(1'b0, 8'h55, 1'b0, "basic_55", 1'b0, 8'h00, -1, waited);
    check("basic_55_accept_wait", waited, 0);

    foreach (vecs[k]) begin
      frame(vecs[k].sel, vecs[k].data, vecs[k].exp_par,
            $sformatf("vec%0d_%02h", k, vecs[k].data), 1'b0, 8'h00, -1, waited);
      repeat (2) @(negedge CLOCK);
    end

    // Back-to-back: valid stays high, next byte accepted right after the idle cycle.
    frame(1'b0, 8'hA5, 1'b0, "b2b_a5", 1'b1, 8'h3C, -1, waited);
    frame(1'b0, 8'h3C, 1'b0, "b2b_3c", 1'b0, 8'h00, -1, waited);
    check("b2b_gap_wait", waited, 0);
    repeat (2) @(negedge CLOCK);

    // Busy ignore: data goes to 0xFF with valid high mid-frame, valid drops in the stop bit.
    frame(1'b0, 8'h00, 1'b0, "ign_00", 1'b1, 8'hFF, NB * CPB0 - 10, waited);
    errs = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLOCK);
      if (out0 !== 1'b1 || ready0 !== 1'b1 || busy0 !== 1'b0) errs++;
    end
    check("ign_no_second_frame", errs, 0);

    // Reset during bit 3 of 0x0F.
    set_in(1'b0, 1'b1, 8'h0F);
    @(posedge CLOCK);
    #1;
    set_in(1'b0, 1'b0, 8'h0F);
    repeat (CPB0 * 4 + 80) @(negedge CLOCK);
    check("rst_mid_busy_before", busy0, 1);
    check("rst_mid_bit3_line",   out0,  1);
    #1;
    RESET = 1'b1;
    #1;
    check("rst_mid_out",   out0,   1);
    check("rst_mid_ready", ready0, 1);
    check("rst_mid_busy",  busy0,  0);
    repeat (3) @(posedge CLOCK);
    @(negedge CLOCK);
    RESET = 1'b0;
    errs = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLOCK);
      if (out0 !== 1'b1 || ready0 !== 1'b1 || busy0 !== 1'b0) errs++;
    end
    check("rst_no_resume", errs, 0);
    frame(1'b0, 8'h81, 1'b0, "rst_then_81", 1'b0, 8'h00, -1, waited);

    // Random bytes against the model, mostly on the short-bit-period instance.
    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom);
      frame(1'b1, d, 1'($countones(d) % 2), $sformatf("rnd1_%0d_%02h", k, d),
            1'b0, 8'h00, -1, waited);
      repeat ($urandom_range(0, 3)) @(negedge CLOCK);
    end
    for (int k = 0; k < 2; k++) begin
      d = 8'($urandom);
      frame(1'b0, d, 1'($countones(d) % 2), $sformatf("rnd0_%0d_%02h", k, d),
            1'b0, 8'h00, -1, waited);
      @(negedge CLOCK);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
